// File: rtl/vga_timing_pkg.sv
// rtl/vga_timing_pkg.sv - Mode constant sets and helpers for the raster timing generator.
package vga_timing_pkg;

    typedef struct packed {
        int sync;
        int bp;
        int active;
        int fp;
    } axis_mode_t;

    // Legacy 640x480 timing (800x521 total)
    localparam axis_mode_t LEGACY_H  = '{sync: 128, bp: 16, active: 640, fp: 16};
    localparam axis_mode_t LEGACY_V  = '{sync: 2,   bp: 29, active: 480, fp: 10};
    localparam int         LEGACY_CW = 10;

    // 800x600@60 (1056x628 total)
    localparam axis_mode_t SVGA60_H  = '{sync: 128, bp: 88, active: 800, fp: 40};
    localparam axis_mode_t SVGA60_V  = '{sync: 4,   bp: 23, active: 600, fp: 1};
    localparam int         SVGA60_CW = 11;

    function automatic int total(input int sync, input int bp, input int active, input int fp);
        return sync + bp + active + fp;
    endfunction

endpackage

// File: rtl/vga_axis_counter.sv
// rtl/vga_axis_counter.sv - One raster axis: wrapping counter with registered sync/active/position decode.
module vga_axis_counter
    import vga_timing_pkg::*;
#(
    parameter int SYNC   = 128,
    parameter int BP     = 16,
    parameter int ACTIVE = 640,
    parameter int FP     = 16,
    parameter bit POL    = 1'b0,
    parameter int CW     = 10
) (
    input  logic          clk_i,
    input  logic          clr_i,
    input  logic          advance_i,
    output logic [CW-1:0] count_o,
    output logic          sync_o,
    output logic          active_o,
    output logic [CW-1:0] pos_o,
    output logic          wrap_o
);

    localparam int TOTAL = total(SYNC, BP, ACTIVE, FP);

    if (SYNC == 0 || BP == 0 || ACTIVE == 0 || FP == 0) begin : g_bad_region
        $error("vga_axis_counter: every timing region must be non-zero");
    end
    if (TOTAL - 1 > (2 ** CW) - 1) begin : g_bad_width
        $error("vga_axis_counter: TOTAL-1 does not fit in CW bits");
    end

    localparam logic [CW-1:0] LAST     = CW'(TOTAL - 1);
    localparam logic [CW-1:0] SYNC_END = CW'(SYNC);
    localparam logic [CW-1:0] ACT_LO   = CW'(SYNC + BP);
    localparam logic [CW-1:0] ACT_HI   = CW'(SYNC + BP + ACTIVE);

    logic [CW-1:0] count_q, count_d;
    logic          sync_q, sync_d;
    logic          active_q, active_d;
    logic [CW-1:0] pos_q, pos_d;
    logic          at_last;

    assign at_last = (count_q == LAST);
    assign wrap_o  = advance_i && at_last;

    // Decode from the next count so the flags line up with the count they describe.
    always_comb begin
        count_d = count_q;
        if (advance_i) begin
            count_d = at_last ? '0 : count_q + 1'b1;
        end
        sync_d   = (count_d < SYNC_END) ? POL : ~POL;
        active_d = (count_d >= ACT_LO) && (count_d < ACT_HI);
        pos_d    = active_d ? (count_d - ACT_LO) : '0;
    end

    always_ff @(posedge clk_i) begin
        if (clr_i) begin
            count_q  <= '0;
            sync_q   <= POL;
            active_q <= 1'b0;
            pos_q    <= '0;
        end else begin
            count_q  <= count_d;
            sync_q   <= sync_d;
            active_q <= active_d;
            pos_q    <= pos_d;
        end
    end

    assign count_o  = count_q;
    assign sync_o   = sync_q;
    assign active_o = active_q;
    assign pos_o    = pos_q;

endmodule

// File: rtl/vga_timing_gen.sv
// rtl/vga_timing_gen.sv - Parametrised raster timing generator with pixel-clock enable.
module vga_timing_gen
    import vga_timing_pkg::*;
#(
    parameter int H_SYNC   = LEGACY_H.sync,
    parameter int H_BP     = LEGACY_H.bp,
    parameter int H_ACTIVE = LEGACY_H.active,
    parameter int H_FP     = LEGACY_H.fp,
    parameter int V_SYNC   = LEGACY_V.sync,
    parameter int V_BP     = LEGACY_V.bp,
    parameter int V_ACTIVE = LEGACY_V.active,
    parameter int V_FP     = LEGACY_V.fp,
    parameter bit HS_POL   = 1'b0,
    parameter bit VS_POL   = 1'b0,
    parameter int CW       = LEGACY_CW
) (
    input  logic          clk_i,
    input  logic          clr_i,
    input  logic          ce_i,
    output logic [CW-1:0] hc_o,
    output logic [CW-1:0] vc_o,
    output logic          hsync_o,
    output logic          vsync_o,
    output logic          vidon_o,
    output logic [CW-1:0] x_o,
    output logic [CW-1:0] y_o,
    output logic          line_end_o,
    output logic          frame_end_o
);

    logic          h_active, v_active;
    logic [CW-1:0] h_pos, v_pos;
    logic          h_wrap, v_wrap;

    vga_axis_counter #(
        .SYNC   (H_SYNC),
        .BP     (H_BP),
        .ACTIVE (H_ACTIVE),
        .FP     (H_FP),
        .POL    (HS_POL),
        .CW     (CW)
    ) u_h (
        .clk_i     (clk_i),
        .clr_i     (clr_i),
        .advance_i (ce_i),
        .count_o   (hc_o),
        .sync_o    (hsync_o),
        .active_o  (h_active),
        .pos_o     (h_pos),
        .wrap_o    (h_wrap)
    );

    // The vertical axis steps on the very edge the horizontal one wraps.
    vga_axis_counter #(
        .SYNC   (V_SYNC),
        .BP     (V_BP),
        .ACTIVE (V_ACTIVE),
        .FP     (V_FP),
        .POL    (VS_POL),
        .CW     (CW)
    ) u_v (
        .clk_i     (clk_i),
        .clr_i     (clr_i),
        .advance_i (h_wrap),
        .count_o   (vc_o),
        .sync_o    (vsync_o),
        .active_o  (v_active),
        .pos_o     (v_pos),
        .wrap_o    (v_wrap)
    );

    // h_active is low on both sides of a line wrap, so this AND never glitches.
    assign vidon_o     = h_active && v_active;
    assign x_o         = vidon_o ? h_pos : '0;
    assign y_o         = v_pos;
    assign line_end_o  = h_wrap;
    assign frame_end_o = v_wrap;

endmodule

// File: tb/tb_vga_timing_gen.sv
// tb/tb_vga_timing_gen.sv - Table-driven bench for vga_timing_gen over three timing configurations.
module tb_vga_timing_gen;

    typedef struct {
        int hc, vc;
        bit hs, vs, vid;
        int x, y;
        bit le, fe;
    } obs_t;

    typedef struct {
        int   dut;
        bit   clr;
        bit   ce;
        int   n;
        obs_t exp;
    } vec_t;

    logic clk = 1'b0;
    logic clr = 1'b0;
    logic ce  = 1'b0;
    int   sel = 0;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    // dut 0: default 800x521
    logic [9:0] d_hc, d_vc, d_x, d_y;
    logic       d_hs, d_vs, d_vid, d_le, d_fe;
    vga_timing_gen u_def (
        .clk_i(clk), .clr_i(clr), .ce_i(ce),
        .hc_o(d_hc), .vc_o(d_vc), .hsync_o(d_hs), .vsync_o(d_vs), .vidon_o(d_vid),
        .x_o(d_x), .y_o(d_y), .line_end_o(d_le), .frame_end_o(d_fe)
    );

    // dut 1: short lines (8 px), default vertical timing
    logic [9:0] t_hc, t_vc, t_x, t_y;
    logic       t_hs, t_vs, t_vid, t_le, t_fe;
    vga_timing_gen #(
        .H_SYNC(2), .H_BP(1), .H_ACTIVE(4), .H_FP(1)
    ) u_tall (
        .clk_i(clk), .clr_i(clr), .ce_i(ce),
        .hc_o(t_hc), .vc_o(t_vc), .hsync_o(t_hs), .vsync_o(t_vs), .vidon_o(t_vid),
        .x_o(t_x), .y_o(t_y), .line_end_o(t_le), .frame_end_o(t_fe)
    );

    // dut 2: small mode, positive sync polarities, 8x6
    logic [3:0] s_hc, s_vc, s_x, s_y;
    logic       s_hs, s_vs, s_vid, s_le, s_fe;
    vga_timing_gen #(
        .H_SYNC(2), .H_BP(1), .H_ACTIVE(4), .H_FP(1),
        .V_SYNC(1), .V_BP(1), .V_ACTIVE(3), .V_FP(1),
        .HS_POL(1'b1), .VS_POL(1'b1), .CW(4)
    ) u_small (
        .clk_i(clk), .clr_i(clr), .ce_i(ce),
        .hc_o(s_hc), .vc_o(s_vc), .hsync_o(s_hs), .vsync_o(s_vs), .vidon_o(s_vid),
        .x_o(s_x), .y_o(s_y), .line_end_o(s_le), .frame_end_o(s_fe)
    );

    obs_t act;
    always_comb begin
        act = '{hc: 0, vc: 0, hs: 1'b0, vs: 1'b0, vid: 1'b0, x: 0, y: 0, le: 1'b0, fe: 1'b0};
        case (sel)
            0: act = '{hc: int'(d_hc), vc: int'(d_vc), hs: d_hs, vs: d_vs, vid: d_vid,
                       x: int'(d_x), y: int'(d_y), le: d_le, fe: d_fe};
            1: act = '{hc: int'(t_hc), vc: int'(t_vc), hs: t_hs, vs: t_vs, vid: t_vid,
                       x: int'(t_x), y: int'(t_y), le: t_le, fe: t_fe};
            default: act = '{hc: int'(s_hc), vc: int'(s_vc), hs: s_hs, vs: s_vs, vid: s_vid,
                             x: int'(s_x), y: int'(s_y), le: s_le, fe: s_fe};
        endcase
    end

    task automatic chk(input string name, input int got, input int want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s got %0d expected %0d", name, got, want);
        end
    endtask

    function automatic vec_t mk(input int dut, input bit c, input bit e, input int n,
                                input int hc, input int vc, input bit hs, input bit vs,
                                input bit vid, input int x, input int y, input bit le,
                                input bit fe);
        vec_t v;
        v.dut = dut; v.clr = c; v.ce = e; v.n = n;
        v.exp = '{hc: hc, vc: vc, hs: hs, vs: vs, vid: vid, x: x, y: y, le: le, fe: fe};
        return v;
    endfunction

    vec_t vecs[$];

    initial begin
        //               dut clr ce  n      hc   vc   hs vs vid x    y    le fe
        vecs.push_back(mk(0, 1, 1, 3,     0,   0,   0, 0, 0, 0,   0,   0, 0));
        vecs.push_back(mk(0, 0, 1, 127,   127, 0,   0, 0, 0, 0,   0,   0, 0));
        vecs.push_back(mk(0, 0, 1, 1,     128, 0,   1, 0, 0, 0,   0,   0, 0));
        vecs.push_back(mk(0, 0, 1, 24671, 799, 30,  1, 1, 0, 0,   0,   1, 0));
        vecs.push_back(mk(0, 0, 1, 1,     0,   31,  0, 1, 0, 0,   0,   0, 0));
        vecs.push_back(mk(0, 0, 1, 143,   143, 31,  1, 1, 0, 0,   0,   0, 0));
        vecs.push_back(mk(0, 0, 1, 1,     144, 31,  1, 1, 1, 0,   0,   0, 0));
        vecs.push_back(mk(0, 0, 1, 639,   783, 31,  1, 1, 1, 639, 0,   0, 0));
        vecs.push_back(mk(0, 0, 1, 1,     784, 31,  1, 1, 0, 0,   0,   0, 0));
        vecs.push_back(mk(0, 0, 1, 15,    799, 31,  1, 1, 0, 0,   0,   1, 0));
        vecs.push_back(mk(0, 0, 1, 1,     0,   32,  0, 1, 0, 0,   1,   0, 0));
        vecs.push_back(mk(0, 0, 0, 5,     0,   32,  0, 1, 0, 0,   1,   0, 0));
        vecs.push_back(mk(0, 0, 1, 300,   300, 32,  1, 1, 1, 156, 1,   0, 0));
        vecs.push_back(mk(0, 1, 0, 1,     0,   0,   0, 0, 0, 0,   0,   0, 0));
        vecs.push_back(mk(0, 0, 0, 3,     0,   0,   0, 0, 0, 0,   0,   0, 0));
        vecs.push_back(mk(0, 0, 1, 1,     1,   0,   0, 0, 0, 0,   0,   0, 0));
        vecs.push_back(mk(1, 1, 1, 3,     0,   0,   0, 0, 0, 0,   0,   0, 0));
        vecs.push_back(mk(1, 0, 1, 15,    7,   1,   1, 0, 0, 0,   0,   1, 0));
        vecs.push_back(mk(1, 0, 1, 1,     0,   2,   0, 1, 0, 0,   0,   0, 0));
        vecs.push_back(mk(1, 0, 1, 235,   3,   31,  1, 1, 1, 0,   0,   0, 0));
        vecs.push_back(mk(1, 0, 1, 3835,  6,   510, 1, 1, 1, 3,   479, 0, 0));
        vecs.push_back(mk(1, 0, 1, 1,     7,   510, 1, 1, 0, 0,   479, 1, 0));
        vecs.push_back(mk(1, 0, 1, 80,    7,   520, 1, 1, 0, 0,   0,   1, 1));
        vecs.push_back(mk(1, 0, 1, 1,     0,   0,   0, 0, 0, 0,   0,   0, 0));
        vecs.push_back(mk(2, 1, 1, 3,     0,   0,   1, 1, 0, 0,   0,   0, 0));
        vecs.push_back(mk(2, 0, 1, 2,     2,   0,   0, 1, 0, 0,   0,   0, 0));
        vecs.push_back(mk(2, 0, 1, 17,    3,   2,   0, 0, 1, 0,   0,   0, 0));
        vecs.push_back(mk(2, 0, 1, 28,    7,   5,   0, 0, 0, 0,   0,   1, 1));
        vecs.push_back(mk(2, 0, 1, 1,     0,   0,   1, 1, 0, 0,   0,   0, 0));
        vecs.push_back(mk(2, 0, 1, 1,     1,   0,   1, 1, 0, 0,   0,   0, 0));
        vecs.push_back(mk(2, 0, 1, 48,    1,   0,   1, 1, 0, 0,   0,   0, 0));
        vecs.push_back(mk(2, 0, 1, 37,    6,   4,   0, 0, 1, 3,   2,   0, 0));

        foreach (vecs[i]) begin
            sel = vecs[i].dut;
            clr = vecs[i].clr;
            ce  = vecs[i].ce;
            repeat (vecs[i].n) @(posedge clk);
            #1;
            chk($sformatf("v%0d_hc", i), act.hc, vecs[i].exp.hc);
            chk($sformatf("v%0d_vc", i), act.vc, vecs[i].exp.vc);
            chk($sformatf("v%0d_hsync", i), int'(act.hs), int'(vecs[i].exp.hs));
            chk($sformatf("v%0d_vsync", i), int'(act.vs), int'(vecs[i].exp.vs));
            chk($sformatf("v%0d_vidon", i), int'(act.vid), int'(vecs[i].exp.vid));
            chk($sformatf("v%0d_x", i), act.x, vecs[i].exp.x);
            chk($sformatf("v%0d_y", i), act.y, vecs[i].exp.y);
            chk($sformatf("v%0d_line_end", i), int'(act.le), int'(vecs[i].exp.le));
            chk($sformatf("v%0d_frame_end", i), int'(act.fe), int'(vecs[i].exp.fe));
        end

        // CE at half rate on the default mode: one line spans 1600 clocks.
        begin
            int exp_hc, exp_vc, track_err, le_hits, le_cycle;
            sel = 0;
            clr = 1'b1;
            ce  = 1'b1;
            repeat (3) @(posedge clk);
            #1;
            clr = 1'b0;
            exp_hc = 0; exp_vc = 0; track_err = 0; le_hits = 0; le_cycle = -1;
            for (int i = 0; i < 1600; i++) begin
                ce = (i % 2 == 0);
                #1;
                if (act.hc != exp_hc || act.vc != exp_vc) track_err++;
                if (act.le != (ce && exp_hc == 799)) track_err++;
                if (!ce && act.fe) track_err++;
                if (act.le) begin
                    le_hits++;
                    le_cycle = i;
                end
                @(posedge clk);
                #1;
                if (ce) begin
                    if (exp_hc == 799) begin
                        exp_hc = 0;
                        exp_vc++;
                    end else begin
                        exp_hc++;
                    end
                end
            end
            chk("half_ce_tracking_errors", track_err, 0);
            chk("half_ce_line_end_count", le_hits, 1);
            chk("half_ce_line_end_cycle", le_cycle, 1598);
            chk("half_ce_end_hc", act.hc, 0);
            chk("half_ce_end_vc", act.vc, 1);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
